// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared defaults, controller state and lane geometry
package sram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 70;
    localparam int LANES_DEF  = 10;
    localparam int LANE_W     = DATA_W_DEF / LANES_DEF;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/sram_init_sweeper.sv
// sram_init_sweeper: walks every array address once after reset so the
// controller can zero-fill the macro before serving requests
module sram_init_sweeper
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              RW0_clk,
    input  logic              rst_n,
    output logic              last,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge RW0_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            cnt  <= cnt + 1'b1;
            done <= &cnt;
        end
    end

    always_comb begin
        addr = cnt;
        last = !done && (&cnt);
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: owns the single RW port of the lane-masked array,
// zero-fills it after reset, then arbitrates refill writes against lookups
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              RW0_clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_t            state_q;
    state_t            state_d;
    logic [SW-1:0]     starve_cnt;
    logic              sweep_last;
    logic              sweep_done;
    logic [ADDR_W-1:0] sweep_addr;
    logic              run;
    logic              rd_win;
    logic              wr_win;

    sram_init_sweeper #(
        .ADDR_W(ADDR_W)
    ) u_sweep (
        .RW0_clk(RW0_clk),
        .rst_n  (rst_n),
        .last   (sweep_last),
        .done   (sweep_done),
        .addr   (sweep_addr)
    );

    always_ff @(posedge RW0_clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == INIT && sweep_last) ? RUN : state_q;
        run     = state_q == RUN;
        // a starved read overrides the default write priority
        rd_win  = run && rd_valid && (!wr_valid || starve_cnt == STARVE_TOP);
        wr_win  = run && wr_valid && !rd_win;
    end

    always_ff @(posedge RW0_clk or negedge rst_n) begin
        if (!rst_n)                          starve_cnt <= '0;
        else if (!run || rd_win || !rd_valid) starve_cnt <= '0;
        else if (starve_cnt != STARVE_TOP)    starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge RW0_clk or negedge rst_n) begin
        if (!rst_n) rd_resp_valid <= 1'b0;
        else        rd_resp_valid <= rd_win;
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (!run) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_addr;
            sram_wmask = '1;
        end else if (wr_win) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wr_addr;
            sram_wmask = wr_mask;
            sram_wdata = wr_data;
        end else if (rd_win) begin
            sram_en    = 1'b1;
            sram_addr  = rd_addr;
        end
    end

    assign wr_ready     = wr_win;
    assign rd_ready     = rd_win;
    assign init_done    = sweep_done;
    assign rd_resp_data = sram_rdata;

    a_one_grant: assert property (@(posedge RW0_clk) disable iff (!rst_n) !(wr_ready && rd_ready));
    a_done_run:  assert property (@(posedge RW0_clk) disable iff (!rst_n) init_done == run);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized scoreboard bench with a lane-masked array model
module tb_sram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 70;
    localparam int LN = 10;
    localparam int LW = DW / LN;
    localparam int SMAX = 4;

    logic          RW0_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [LN-1:0] wr_mask = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_resp_data;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic          sram_en;
    logic          sram_wmode;
    logic [LN-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LANES(LN), .STARVE_MAX(SMAX)) dut (
        .RW0_clk(RW0_clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .init_done(init_done),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 RW0_clk = ~RW0_clk;

    logic [DW-1:0] mem [1 << AW];
    always @(posedge RW0_clk) begin
        if (sram_en && sram_wmode) begin
            for (int l = 0; l < LN; l++)
                if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
        end else if (sram_en) begin
            sram_rdata <= mem[sram_addr];
        end
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [1 << AW];
    int            waited = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_v;

    always @(posedge RW0_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd70();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    always @(negedge RW0_clk) begin
        if (rst_n) begin
            mon_v = q.size() > 0 && q[0].due == cyc;
            if (mon_v || rd_resp_valid) begin
                check("resp_valid", {69'd0, rd_resp_valid}, {69'd0, mon_v});
                if (mon_v) begin
                    if (rd_resp_valid) check("resp_data", rd_resp_data, q[0].data);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic cycle(input bit wv, input logic [AW-1:0] wa, input logic [LN-1:0] wm,
                         input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] ra);
        bit er, ew;
        @(negedge RW0_clk);
        wr_valid = wv; wr_addr = wa; wr_mask = wm; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
        er = rv && (!wv || waited >= SMAX);
        ew = wv && !er;
        #1;
        check("wr_ready", {69'd0, wr_ready}, {69'd0, ew});
        check("rd_ready", {69'd0, rd_ready}, {69'd0, er});
        if (ew)
            for (int l = 0; l < LN; l++)
                if (wm[l]) ref_mem[wa][l*LW +: LW] = wd[l*LW +: LW];
        if (er) begin
            q.push_back('{cyc + 1, ref_mem[ra]});
            waited = 0;
        end else begin
            waited = rv ? waited + 1 : 0;
        end
    endtask

    task automatic run_init(input int abort_at);
        int k;
        bit pins_ok, rdy_ok;
        k = 0; pins_ok = 1; rdy_ok = 1;
        @(negedge RW0_clk);
        rst_n = 1'b1;
        wr_valid = 1'b1; rd_valid = 1'b1;
        while (!init_done && k < 1100) begin
            #1;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_addr", {60'd0, sram_addr}, '0);
                check("abort_done", {69'd0, init_done}, '0);
                wr_valid = 1'b0; rd_valid = 1'b0;
                return;
            end
            if (sram_addr != k[AW-1:0] || !sram_en || !sram_wmode || sram_wmask != '1 || sram_wdata != '0)
                pins_ok = 0;
            if (wr_ready || rd_ready) rdy_ok = 0;
            @(negedge RW0_clk);
            k++;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        check("init_len", DW'(k), DW'(1 << AW));
        check("init_pins", {69'd0, pins_ok}, 70'd1);
        check("init_ready", {69'd0, rdy_ok}, 70'd1);
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        waited = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #3;
        check("rst_done", {69'd0, init_done}, '0);
        check("rst_resp", {69'd0, rd_resp_valid}, '0);
        check("rst_wr_ready", {69'd0, wr_ready}, '0);
        check("rst_rd_ready", {69'd0, rd_ready}, '0);
        check("rst_addr", {60'd0, sram_addr}, '0);
        repeat (2) @(negedge RW0_clk);
        run_init(-1);

        cycle(0, '0, '0, '0, 1, 10'd0);
        cycle(0, '0, '0, '0, 1, 10'd511);
        cycle(0, '0, '0, '0, 1, 10'd1023);
        cycle(0, '0, '0, '0, 0, '0);

        cycle(1, 10'd5, 10'h3FF, '1, 0, '0);
        cycle(0, '0, '0, '0, 1, 10'd5);
        cycle(1, 10'd7, 10'h001, '1, 0, '0);
        cycle(0, '0, '0, '0, 1, 10'd7);
        cycle(0, '0, '0, '0, 0, '0);

        n = 0;
        rd_ready_seen: while (n < 20) begin
            cycle(1, 10'($urandom_range(16, 31)), 10'($urandom), rnd70(), 1, 10'd5);
            n++;
            if (rd_ready) break;
        end
        check("starve_grant_cycle", DW'(n), DW'(SMAX + 1));
        cycle(0, '0, '0, '0, 0, '0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 10'($urandom_range(0, 15)), 10'($urandom), rnd70(),
                  $urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)));
        repeat (3) cycle(0, '0, '0, '0, 0, '0);
        check("scoreboard_drain", DW'(q.size()), '0);

        cycle(0, '0, '0, '0, 1, 10'd3);
        @(negedge RW0_clk);
        rd_valid = 1'b0;
        @(posedge RW0_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midread_resp_clear", {69'd0, rd_resp_valid}, '0);
        q.delete();
        repeat (3) @(negedge RW0_clk);
        run_init(300);
        repeat (3) @(negedge RW0_clk);
        run_init(-1);

        cycle(0, '0, '0, '0, 1, 10'd5);
        cycle(0, '0, '0, '0, 1, 10'd7);
        repeat (3) cycle(0, '0, '0, '0, 0, '0);
        check("final_drain", DW'(q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
